// File: rtl/alu.sv
// Registered two-operand ALU (ADD/SUB/AND/OR) with zero/carry/overflow flags, latency 1.
// Optional signed saturation for ADD/SUB when ALU_SAT_EN is defined.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] result_d, result_q;
    logic             out_valid_d, out_valid_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] op_result;
    logic             op_carry;
    logic             op_overflow;
    op_e              op;

    always_comb begin
        op          = op_e'(control);
        sum_ext     = {1'b0, c} + {1'b0, d};
        // The extra top bit of the widened difference is the unsigned borrow.
        diff_ext    = {1'b0, c} - {1'b0, d};
        op_result   = '0;
        op_carry    = 1'b0;
        op_overflow = 1'b0;
        case (op)
            OP_ADD: begin
                op_result   = sum_ext[WIDTH-1:0];
                op_carry    = sum_ext[WIDTH];
                op_overflow = (c[WIDTH-1] == d[WIDTH-1]) &&
                              (sum_ext[WIDTH-1] != c[WIDTH-1]);
            end
            OP_SUB: begin
                op_result   = diff_ext[WIDTH-1:0];
                op_carry    = diff_ext[WIDTH];
                op_overflow = (c[WIDTH-1] != d[WIDTH-1]) &&
                              (diff_ext[WIDTH-1] != c[WIDTH-1]);
            end
            OP_AND: op_result = c & d;
            OP_OR:  op_result = c | d;
            default: op_result = '0;
        endcase
`ifdef ALU_SAT_EN
        // On overflow the true result has the sign of c, so clamp toward that sign.
        if (op_overflow) begin
            op_result = c[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            result_d    = op_result;
            carry_d     = op_carry;
            overflow_d  = op_overflow;
            out_valid_d = 1'b1;
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

    // Saturation bounds are referenced only when ALU_SAT_EN is defined.
    logic unused_sat;
    assign unused_sat = ^{SAT_MAX, SAT_MIN};

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH=32); expectations follow ALU_SAT_EN when defined.
module tb_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       control;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic             carry;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .c        (c),
        .d        (d),
        .control  (control),
        .result   (result),
        .out_valid(out_valid),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic rst_v, input logic valid_v,
                                 input logic [WIDTH-1:0] c_v, input logic [WIDTH-1:0] d_v,
                                 input logic [1:0] ctl_v);
        @(negedge clk);
        rst_n    = rst_v;
        in_valid = valid_v;
        c        = c_v;
        d        = d_v;
        control  = ctl_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [WIDTH-1:0] exp_result,
                            input logic exp_valid, input logic exp_zero,
                            input logic exp_carry, input logic exp_ovf);
        checkOutput({tag, ".result"},    result,          exp_result);
        checkOutput({tag, ".out_valid"}, 32'(out_valid),  32'(exp_valid));
        checkOutput({tag, ".zero"},      32'(zero),       32'(exp_zero));
        checkOutput({tag, ".carry"},     32'(carry),      32'(exp_carry));
        checkOutput({tag, ".overflow"},  32'(overflow),   32'(exp_ovf));
    endtask

    logic [WIDTH-1:0] exp_pos_ovf;
    logic [WIDTH-1:0] exp_neg_ovf;

    initial begin
`ifdef ALU_SAT_EN
        exp_pos_ovf = 32'h7FFF_FFFF;
        exp_neg_ovf = 32'h8000_0000;
`else
        exp_pos_ovf = 32'h8000_0000;
        exp_neg_ovf = 32'h7FFF_FFFF;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        c        = '0;
        d        = '0;
        control  = 2'b00;

        // Reset held two cycles while an op is offered: reset must win.
        applyStimulus(1'b0, 1'b1, 32'd4, 32'd3, 2'b00);
        applyStimulus(1'b0, 1'b1, 32'd4, 32'd3, 2'b00);
        checkAll("reset", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Four back-to-back ops on c=4 d=3.
        applyStimulus(1'b1, 1'b1, 32'd4, 32'd3, 2'b01);
        checkAll("sub_4_3", 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd4, 32'd3, 2'b00);
        checkAll("add_4_3", 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd4, 32'd3, 2'b10);
        checkAll("and_4_3", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd4, 32'd3, 2'b11);
        checkAll("or_4_3", 32'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // Idle cycles: out_valid drops, result and flags hold despite new operands.
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 2'b01);
        checkAll("idle1", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 2'b10);
        checkAll("idle2", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Borrow and carry-out boundaries.
        applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, 2'b01);
        checkAll("sub_borrow", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00);
        checkAll("add_carry", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Signed overflow in both directions.
        applyStimulus(1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00);
        checkAll("add_ovf", exp_pos_ovf, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'd1, 2'b01);
        checkAll("sub_ovf", exp_neg_ovf, 1'b1, 1'b0, 1'b0, 1'b1);

        // Mixed bit patterns for the logic ops clear stale flags.
        applyStimulus(1'b1, 1'b1, 32'hF0F0_A5A5, 32'h0FF0_5A0F, 2'b10);
        checkAll("and_mix", 32'h00F0_0005, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hF0F0_A5A5, 32'h0FF0_5A0F, 2'b11);
        checkAll("or_mix", 32'hFFF0_FFAF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream with in_valid high discards the op.
        applyStimulus(1'b1, 1'b1, 32'd10, 32'd20, 2'b00);
        checkAll("pre_reset", 32'd30, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd3, 32'd4, 2'b01);
        checkAll("mid_reset", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'd100, 32'd58, 2'b01);
        checkAll("post_reset", 32'd42, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
